// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory server.
// Fetch-count output is enabled by defining IMEM_FETCH_COUNT_EN.
package imem_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-clock DEPTH x 32 program RAM: one synchronous write port, one
// synchronous read port, no reset on contents.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_memory_server.sv
// Instruction memory responder: LOAD/RUN/HALT control, range checks, counters
// and response muxing around imem_ram. Optional macro: IMEM_FETCH_COUNT_EN.
module instruction_memory_server
  import imem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               load_start,
  input  logic               load_en,
  input  logic [31:0]        load_addr,
  input  logic [31:0]        load_data,
  input  logic               load_commit,
  output logic [15:0]        load_count,
  output logic               busy,
`ifdef IMEM_FETCH_COUNT_EN
  output logic [31:0]        fetch_count,
`endif
  output logic               fault
);

  imem_state_t        r_state;
  imem_state_t        w_state_next;
  logic               r_valid;
  logic               r_nop;
  logic               r_fault;
  logic [15:0]        r_load_count;
  logic               w_fetch_in_range;
  logic               w_load_in_range;
  logic               w_fetch_accept;
  logic               w_write;
  logic [INSTR_W-1:0] w_rdata;

  // Full 32-bit compares so high address bits can never alias into the RAM.
  assign w_fetch_in_range = (fetch_addr < 32'(DEPTH));
  assign w_load_in_range  = (load_addr  < 32'(DEPTH));
  assign w_fetch_accept   = (r_state == RUN) && fetch_req && !load_start;
  assign w_write          = (r_state == LOAD) && load_en && w_load_in_range && !load_start;

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (load_addr[AW-1:0]),
    .i_wdata (load_data),
    .i_re    (w_fetch_accept && w_fetch_in_range),
    .i_raddr (fetch_addr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD: begin
        if (!load_start && load_commit) w_state_next = RUN;
      end
      RUN: begin
        if (load_start)                                  w_state_next = LOAD;
        else if (fetch_req && !w_fetch_in_range)         w_state_next = HALT;
      end
      HALT: begin
        if (load_start) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= LOAD;
      r_valid      <= 1'b0;
      r_nop        <= 1'b0;
      r_fault      <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_fetch_accept;
      r_nop   <= w_fetch_accept && !w_fetch_in_range;
      if (load_start) begin
        r_fault <= 1'b0;
      end else if (w_fetch_accept && !w_fetch_in_range) begin
        r_fault <= 1'b1;
      end
      if (load_start) begin
        r_load_count <= '0;
      end else if (w_write && (r_load_count != 16'hFFFF)) begin
        r_load_count <= r_load_count + 16'd1;
      end
    end
  end

`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_count <= '0;
    end else if (load_start) begin
      r_fetch_count <= '0;
    end else if (w_fetch_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

  // Idle cycles return zero to match the fetch unit clearing its instruction.
  assign instr_out   = r_valid ? (r_nop ? NOP_INSTR : w_rdata) : '0;
  assign instr_valid = r_valid;
  assign fault       = r_fault;
  assign busy        = (r_state == LOAD);
  assign load_count  = r_load_count;

endmodule

// File: tb/tb_instruction_memory_server.sv
// Self-checking bench for instruction_memory_server: reference model feeds a
// scoreboard queue of expected responses, checked one cycle after each request.
module tb_instruction_memory_server;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          M_LOAD = 0, M_RUN = 1, M_HALT = 2;

  logic        clk, resetn;
  logic        fetchReq, loadStart, loadEn, loadCommit;
  logic [31:0] fetchAddr, loadAddr, loadData, instrOut;
  logic        instrValid, busy, fault;
  logic [15:0] loadCount;
`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] fetchCount;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] data;
  } respT;

  respT        sbQ[$];
  logic [31:0] mRam [DEPTH];
  int          mState;
  logic        mFault;
  logic [15:0] mLoadCount;
  logic [31:0] mFetchCount;
  int          errors = 0;
  int          checks = 0;

  instruction_memory_server #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_req   (fetchReq),
    .fetch_addr  (fetchAddr),
    .instr_out   (instrOut),
    .instr_valid (instrValid),
    .load_start  (loadStart),
    .load_en     (loadEn),
    .load_addr   (loadAddr),
    .load_data   (loadData),
    .load_commit (loadCommit),
    .load_count  (loadCount),
    .busy        (busy),
`ifdef IMEM_FETCH_COUNT_EN
    .fetch_count (fetchCount),
`endif
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState      = M_LOAD;
    mFault      = 1'b0;
    mLoadCount  = '0;
    mFetchCount = '0;
    sbQ.delete();
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, ".busy"},  {31'd0, busy},  {31'd0, mState == M_LOAD});
    checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, mFault});
    checkOutput({tag, ".lcnt"},  {16'd0, loadCount}, {16'd0, mLoadCount});
`ifdef IMEM_FETCH_COUNT_EN
    checkOutput({tag, ".fcnt"},  fetchCount, mFetchCount);
`endif
  endtask

  // One clock: drive at negedge, predict the response, check after the edge.
  task automatic applyStimulus(input string tag, input logic fr, input logic [31:0] fa,
                               input logic ls, input logic le, input logic [31:0] la,
                               input logic [31:0] ld, input logic lc);
    respT exp, got;
    @(negedge clk);
    fetchReq = fr; fetchAddr = fa; loadStart = ls; loadEn = le;
    loadAddr = la; loadData = ld; loadCommit = lc;
    exp.valid = 1'b0;
    exp.data  = '0;
    case (mState)
      M_LOAD: begin
        if (ls) begin
          mLoadCount = '0; mFetchCount = '0;
        end else begin
          if (le && la < DEPTH) begin
            mRam[la[7:0]] = ld;
            if (mLoadCount != 16'hFFFF) mLoadCount = mLoadCount + 16'd1;
          end
          if (lc) mState = M_RUN;
        end
      end
      M_RUN: begin
        if (ls) begin
          mState = M_LOAD; mLoadCount = '0; mFetchCount = '0;
        end else if (fr) begin
          exp.valid = 1'b1;
          mFetchCount = mFetchCount + 32'd1;
          if (fa < DEPTH) exp.data = mRam[fa[7:0]];
          else begin
            exp.data = NOP; mFault = 1'b1; mState = M_HALT;
          end
        end
      end
      default: begin
        if (ls) begin
          mState = M_LOAD; mFault = 1'b0; mLoadCount = '0; mFetchCount = '0;
        end
      end
    endcase
    sbQ.push_back(exp);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput({tag, ".valid"}, {31'd0, instrValid}, {31'd0, got.valid});
    checkOutput({tag, ".data"},  instrOut, got.data);
    checkStatus(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    applyStimulus(tag, 1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic write(input string tag, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(tag, 1'b0, '0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    fetchReq = 1'b0; fetchAddr = '0; loadStart = 1'b0; loadEn = 1'b0;
    loadAddr = '0; loadData = '0; loadCommit = 1'b0;
    modelReset();
    #12;
    checkOutput("rst.valid", {31'd0, instrValid}, 32'd0);
    checkOutput("rst.data",  instrOut, 32'd0);
    checkStatus("rst");
    @(negedge clk);
    resetn = 1'b1;

    // Load four words and fetch them back-to-back.
    applyStimulus("start", 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    write("w0", 32'd0, 32'h11111111);
    write("w1", 32'd1, 32'h22222222);
    write("w2", 32'd2, 32'h33333333);
    write("w3", 32'd3, 32'h44444444);
    write("wOor", 32'd256, 32'hDEADBEEF);
    write("wHigh", 32'h80000000, 32'hDEADBEEF);
    applyStimulus("commit", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    fetch("f0", 32'd0);
    fetch("f1", 32'd1);
    fetch("f2", 32'd2);
    fetch("f3", 32'd3);
    idle("idle0");
    fetch("f0again", 32'd0);

    // Loader inputs are ignored while running.
    applyStimulus("runLoadEn", 1'b0, '0, 1'b0, 1'b1, 32'd0, 32'h00000BAD, 1'b1);
    fetch("f0keep", 32'd0);

    // load_start wins over a simultaneous fetch.
    applyStimulus("startFetch", 1'b1, 32'd2, 1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus("fetchInLoad", 1'b1, 32'd1, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus("wCommit", 1'b0, '0, 1'b0, 1'b1, 32'd5, 32'h55555555, 1'b1);
    fetch("f5", 32'd5);
    fetch("f1b", 32'd1);

    // Out-of-range fetch faults and halts.
    fetch("fault", 32'h00000100);
    fetch("halted", 32'd0);
    idle("haltIdle");
    applyStimulus("restart", 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Five good fetches plus a high-address fault (no wrap to index 0).
    applyStimulus("commit2", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    fetch("c0", 32'd0);
    fetch("c1", 32'd1);
    fetch("c2", 32'd2);
    fetch("c3", 32'd3);
    fetch("c5", 32'd5);
    fetch("cFault", 32'hFFFF0000);
    applyStimulus("clrStart", 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset while a faulting response is on the outputs.
    applyStimulus("commit3", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    fetch("b0", 32'd0);
    fetch("b1", 32'd1);
    fetch("bFault", 32'h00000200);
    #2;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.valid", {31'd0, instrValid}, 32'd0);
    checkOutput("arst.data",  instrOut, 32'd0);
    checkStatus("arst");
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus("postRst", 1'b1, 32'd0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus("postCommit", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    fetch("postF3", 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_server.md
Name: instruction_memory_server

Overview:
- Responder end of the instruction-fetch interface: holds program words in a word-addressed RAM and returns one 32-bit instruction per fetch request.
- `instr_valid` drives the fetch unit's `read` input; `instr_out` drives its `instruction_in`.
- A loader port fills the RAM before execution.
- A small state machine separates load, run and halted (fault) operation.

Parameters:
- DEPTH, 256, number of 32-bit instruction words; power of two, 4..65536.
- AW, $clog2(DEPTH), internal RAM index width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch request strobe, one word per cycle
- fetch_addr  in  32  word address (program counter counts words)
- instr_out  out  32  returned instruction
- instr_valid  out  1  instr_out valid this cycle
- load_start  in  1  pulse: enter LOAD
- load_en  in  1  write strobe in LOAD
- load_addr  in  32  write word address
- load_data  in  32  write data
- load_commit  in  1  pulse: leave LOAD, enter RUN
- load_count  out  16  writes accepted since last load_start (saturates at 16'hFFFF)
- busy  out  1  high while in LOAD
- fault  out  1  sticky out-of-range fetch flag

Behaviour:
- Reset (async assert, sync deassert is external) sets these values:
  - state=LOAD; instr_out=0; instr_valid=0; load_count=0; busy=1; fault=0.
  - RAM contents are not reset.
- States: LOAD, RUN, HALT (encoded in imem_pkg).
- LOAD:
  - load_en with load_addr<DEPTH writes RAM[load_addr[AW-1:0]] at the clock edge and increments load_count.
  - load_en with load_addr>=DEPTH: write dropped, load_count unchanged.
  - fetch_req ignored: instr_valid=0, instr_out=0.
  - load_commit -> RUN next cycle. A write in the same cycle as load_commit is still performed.
- RUN:
  - Fetch with fetch_addr<DEPTH:
    - Cycle N+1: instr_valid=1, instr_out=RAM[fetch_addr[AW-1:0]].
    - Latency is exactly 1 cycle; back-to-back requests give back-to-back responses.
  - No fetch_req: next cycle instr_valid=0, instr_out=0. This matches the fetch unit zeroing its instruction when not reading.
  - Fetch with fetch_addr>=DEPTH:
    - Next cycle: instr_valid=1, instr_out=NOP_INSTR (32'h00000013), fault=1.
    - state -> HALT.
  - load_start -> LOAD next cycle; load_count cleared.
    - A simultaneous fetch_req is dropped: no response, instr_valid=0.
  - load_en and load_commit are ignored in RUN.
- HALT:
  - All fetches ignored: instr_valid=0, instr_out=0.
  - fault stays 1.
  - load_start -> LOAD and clears fault. Reset also clears fault.
- busy=1 exactly when state==LOAD (registered with state).
- Priority within a cycle: resetn > load_start > load_commit > load_en / fetch_req.
- Reset asserted mid-burst: instr_valid drops immediately (async). The first cycle after release is LOAD with no response pending.
- Address arithmetic:
  - Range check uses the full 32-bit address; no wrap-around.
  - Only AW LSBs index the RAM.

Optional Feature:
- IMEM_FETCH_COUNT_EN
- Defined:
  - Adds output fetch_count (32 bits), reset 0.
  - Increments on every RUN cycle that produces instr_valid=1, including the faulting NOP response.
  - Wraps at 2^32.
  - Cleared on load_start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- imem_pkg:
  - state enum imem_state_t {LOAD, RUN, HALT}.
  - localparam NOP_INSTR=32'h00000013.
  - localparam INSTR_W=32.
- Sub-module imem_ram: single-clock RAM, one synchronous write port and one synchronous read port, DEPTH x 32, no reset.
- instruction_memory_server holds the FSM, range checks, counters and output muxing.

Test Plan:
- Load and fetch:
  - Reset; load_start; write RAM[0..3]=32'h11111111, 22222222, 33333333, 44444444; load_commit.
  - Fetch addr 0..3 back-to-back -> instr_valid=1 for 4 consecutive cycles starting 1 cycle after the first req; data in order; load_count=4.
- Out-of-range load:
  - In LOAD, write load_addr=DEPTH (256) with 32'hDEADBEEF -> load_count unchanged.
  - Then commit, fetch addr 0 -> previous RAM[0] returned.
- Fault:
  - In RUN, fetch_addr=32'h00000100 -> next cycle instr_valid=1, instr_out=32'h00000013, fault=1.
  - Subsequent fetch_req -> instr_valid=0.
  - load_start -> fault=0, busy=1.
- Simultaneous events:
  - In RUN, assert load_start with fetch_req addr 2 -> no response (instr_valid=0), busy=1 next cycle, load_count=0.
  - load_en with load_commit same cycle -> write visible on first fetch after commit.
- Async reset:
  - Drop resetn mid-burst, between clock edges -> instr_valid=0 and fault=0 before the next edge; state LOAD after release.
- IMEM_FETCH_COUNT_EN:
  - 5 valid fetches + 1 faulting fetch -> fetch_count=6.
  - load_start -> fetch_count=0.
